// File: rtl/instruction_queue.sv
`default_nettype none
// ============================================================================
// Module      : instruction_queue
// Description : Instruction register fed by a DEPTH-entry prefetch FIFO that
//               captures bytes from the shared tri-state bus. The head entry is
//               promoted into the current register on advance; the current
//               register supplies the opcode to the decoder and can drive its
//               operand back onto the bus.
//               Optional macro INSTR_QUEUE_SIGNEXT_EN: sign-extend the operand
//               driven onto the bus (zero-extended when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_queue #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_bus,
    input  logic              advance,
    input  logic              flush,
    input  logic              out_bus,
    inout  wire  [DATA_W-1:0] bus_data,
    output logic [OP_W-1:0]   decoder_data,
    output logic              cur_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_OPR_W = DATA_W - OP_W;
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [DATA_W-1:0]  r_cur;
    logic               r_cur_valid;
    logic               r_overflow;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [DATA_W-1:0]  w_operand_ext;

    assign w_full  = (r_count == c_DEPTH_CNT);
    assign w_empty = (r_count == '0);

    // An advance on an empty queue bypasses the FIFO, so the byte is not stored.
    // A full queue still accepts a push when the head leaves on the same edge.
    assign w_pop  = !flush && advance && !w_empty;
    assign w_push = !flush && in_bus && !(advance && w_empty) && (!w_full || advance);
    assign w_drop = !flush && in_bus && w_full && !advance;

    // Queue storage: written only on accepted pushes, contents never cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus_data;
        end
    end

    // Pointers, occupancy, current instruction and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cur       <= '0;
            r_cur_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cur       <= '0;
            r_cur_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (advance) begin
                if (w_pop) begin
                    r_cur       <= r_mem[r_rd_ptr];
                    r_cur_valid <= 1'b1;
                end else if (in_bus) begin
                    r_cur       <= bus_data;
                    r_cur_valid <= 1'b1;
                end else begin
                    r_cur_valid <= 1'b0;
                end
            end
        end
    end

`ifdef INSTR_QUEUE_SIGNEXT_EN
    assign w_operand_ext = {{OP_W{r_cur[c_OPR_W-1]}}, r_cur[c_OPR_W-1:0]};
`else
    assign w_operand_ext = {{OP_W{1'b0}}, r_cur[c_OPR_W-1:0]};
`endif

    // Operand drive is purely combinational so it appears in the same cycle.
    assign bus_data = out_bus ? w_operand_ext : {DATA_W{1'bz}};

    assign decoder_data = r_cur[DATA_W-1 -: OP_W];
    assign cur_valid    = r_cur_valid;
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: doc/instruction_queue.md
# instruction_queue

Parametrised instruction register with a small prefetch FIFO for the SAP bus-based 8-bit processor. Instruction bytes are captured from the shared tri-state bus into a DEPTH-entry queue ahead of execution. On request, the head entry is promoted into the current-instruction register. That register feeds the opcode field to the control decoder and can drive its operand field back onto the bus.

## Interface
- DATA_W, default 8: bus and instruction width; must satisfy DATA_W > OP_W.
- OP_W, default 4: opcode field width, taken from instruction bits [DATA_W-1 : DATA_W-OP_W].
- DEPTH, default 4: prefetch queue entries; power of two, ≥ 2.
- CNT_W, default $clog2(DEPTH+1): width of the count output. Derived; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_bus  in  1  push bus_data into the queue at the next clk edge.
- advance  in  1  promote the queue head into the current register.
- flush  in  1  discard the queue and invalidate the current instruction.
- out_bus  in  1  drive the current operand onto bus_data.
- bus_data  inout  DATA_W  shared system bus.
- decoder_data  out  OP_W  opcode of the current instruction.
- cur_valid  out  1  current register holds a live instruction.
- count  out  CNT_W  number of queued entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky flag: a push was dropped.

## Operation
- Storage:
  - circular buffer of DEPTH × DATA_W entries;
  - read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH;
  - current register cur (DATA_W) with flag cur_valid.
- Priority per edge: rst > flush > push/advance.
- flush:
  - count, pointers, cur, cur_valid and overflow all go to 0;
  - any in_bus or advance in the same cycle is ignored.
- Push: when in_bus=1, bus_data is written at the write pointer and the pointer increments, if any of the following holds:
  - not full;
  - full and advance=1 in the same cycle.
- Dropped push: when in_bus=1, the queue is full and advance=0, the data is dropped and overflow is set to 1. overflow holds until rst or flush.
- Advance, queue non-empty: cur gets the head entry, cur_valid=1, the read pointer increments.
- Advance, queue empty, in_bus=1: bypass. cur gets bus_data, cur_valid=1, count stays 0.
- Advance, queue empty, in_bus=0: cur_valid=0 and cur holds its value.
- Push and advance together on a non-empty queue: both take effect and count is unchanged.
- decoder_data = cur[DATA_W-1 : DATA_W-OP_W], valid regardless of cur_valid.
- out_bus=1: bus_data is driven with the operand cur[DATA_W-OP_W-1:0], extended to DATA_W per the Configuration section. out_bus=0: high-Z.
- Bus contention: asserting in_bus and out_bus together is illegal. No behaviour is defined.

## Timing
- Reset values: count=0, empty=1, full=0, cur_valid=0, decoder_data=0, overflow=0, bus_data=Z.
- Push-to-visible latency: 1 cycle. count, full and empty update on the edge that accepts the push.
- Advance latency: 1 cycle. decoder_data changes on the edge where advance is sampled.
- Bypass latency: 1 cycle from the bus byte to decoder_data.
- bus_data drive: combinational from out_bus and cur, with no register stage.
- Asynchronous reset mid-operation: all state clears immediately; queued contents are lost. Memory contents need not be cleared, only the pointers.
- full, empty and count are registered-state derived, glitch-free after the edge.

## Configuration
- Macro: INSTR_QUEUE_SIGNEXT_EN.
- Defined: the operand driven onto the bus is sign-extended from bit DATA_W-OP_W-1. Example: with defaults, operand 4'b1010 drives 8'hFA.
- Undefined: the operand is zero-extended. The same example drives 8'h0A.
- decoder_data and the queue are unaffected by the macro.

## Test plan
- Reset and fill: rst, then push 8'h1E, 8'h2F, 8'h3A, 8'h4B. Expect count=4, full=1, empty=0, cur_valid=0, overflow=0.
- Overflow: while full, push 8'h55 with advance=0. Expect overflow=1 and count=4. Then advance four times; decoder_data must be 1, 2, 3, 4 in sequence, with 8'h55 never appearing.
- Simultaneous push and advance on a full queue: expect count to stay 4 and the pushed byte to emerge after the existing three entries.
- Bypass:
  - empty queue, advance=1 with in_bus=1 and bus_data=8'h7C: expect decoder_data=7, cur_valid=1, count=0;
  - next cycle, advance=1 alone: expect cur_valid=0.
- Operand drive with cur=8'h9A and out_bus=1:
  - expect bus_data=8'h0A without INSTR_QUEUE_SIGNEXT_EN, 8'hFA with it;
  - expect Z when out_bus=0.
- Flush and async reset:
  - flush on the same cycle as a push: expect count=0, cur_valid=0, overflow=0, and the push lost;
  - assert rst between clock edges: outputs reach reset values before the next edge.
